// File: rtl/seg_scan_capture.sv
// seg_scan_capture: recovers the 16-bit hex word shown on a scanned, active-low seven-segment bus (SEG/AN).
// Optional feature: define SEGCAP_ERR_EN to flag captured patterns that are not legal hex glyphs (sticky err).
module seg_scan_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  AN,
    input  logic [7:0]  SEG,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic [3:0]  digit_seen,
    output logic        err
);
    typedef enum logic {ST_SCAN, ST_PUBLISH} state_t;

    localparam logic [7:0] L_STABLE = 8'(STABLE_CYCLES);

    state_t      r_state, w_state_next;
    logic [3:0]  r_s_an, r_p_an;
    logic [7:0]  r_s_seg, r_p_seg;
    logic [7:0]  r_cnt, w_cnt_next;
    logic        r_armed;
    logic [15:0] r_slots, r_value, w_slots_next;
    logic [3:0]  r_dps, r_dp, r_seen, w_dps_next;
    logic [3:0]  w_sel, w_nib, w_sh;
    logic [1:0]  w_idx;
    logic        w_valid, w_same, w_cap, w_go;

    // Active-low glyph to nibble; anything unmatched decodes to 0.
    function automatic logic [3:0] glyph_nib(input logic [6:0] g);
        case (g)
            7'h40: return 4'h0;
            7'h79: return 4'h1;
            7'h24: return 4'h2;
            7'h30: return 4'h3;
            7'h19: return 4'h4;
            7'h12: return 4'h5;
            7'h02: return 4'h6;
            7'h78: return 4'h7;
            7'h00: return 4'h8;
            7'h10: return 4'h9;
            7'h08: return 4'hA;
            7'h03: return 4'hB;
            7'h46: return 4'hC;
            7'h21: return 4'hD;
            7'h06: return 4'hE;
            7'h0E: return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    assign w_sel   = ~r_s_an;
    assign w_valid = (w_sel != 4'h0) && ((w_sel & (w_sel - 4'd1)) == 4'h0);
    assign w_idx   = w_sel[3] ? 2'd3 : w_sel[2] ? 2'd2 : w_sel[1] ? 2'd1 : 2'd0;
    assign w_same  = {r_s_an, r_s_seg} == {r_p_an, r_p_seg};
    // The counter holds the number of consecutive identical samples, so a fresh sample already counts as one;
    // this makes a dwell of exactly STABLE_CYCLES input cycles capture at the edge ending cycle t+STABLE_CYCLES.
    assign w_cnt_next = !w_valid ? 8'd0 : !w_same ? 8'd1 : (r_cnt == L_STABLE) ? L_STABLE : r_cnt + 8'd1;
    assign w_cap   = w_valid && (w_cnt_next == L_STABLE) && (r_armed || !w_same);
    assign w_nib   = glyph_nib(r_s_seg[6:0]);
    assign w_sh    = {w_idx, 2'b00};
    assign w_slots_next = w_cap ? ((r_slots & ~(16'hF << w_sh)) | ({12'h0, w_nib} << w_sh)) : r_slots;
    assign w_dps_next   = w_cap ? ((r_dps & ~(4'b1 << w_idx)) | ({3'b0, ~r_s_seg[7]} << w_idx)) : r_dps;
    assign w_go    = (r_state == ST_SCAN) && w_cap && ((r_seen | w_sel) == 4'hF);

    assign value       = r_value;
    assign dp          = r_dp;
    assign digit_seen  = r_seen;
    assign frame_valid = (r_state == ST_PUBLISH);

    // Register the bus once and keep the previous sample for the stability compare.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s_an  <= 4'hF;
            r_s_seg <= 8'hFF;
            r_p_an  <= 4'hF;
            r_p_seg <= 8'hFF;
        end else begin
            r_s_an  <= AN;
            r_s_seg <= SEG;
            r_p_an  <= r_s_an;
            r_p_seg <= r_s_seg;
        end
    end

    // Stability counter; armed allows exactly one capture per dwell.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt   <= 8'd0;
            r_armed <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_next;
            r_armed <= w_cap ? 1'b0 : (!w_same || !w_valid) ? 1'b1 : r_armed;
        end
    end

    // Digit slots and per-frame seen mask; a capture during PUBLISH starts the next frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_slots <= 16'h0;
            r_dps   <= 4'h0;
            r_seen  <= 4'h0;
        end else begin
            r_slots <= w_slots_next;
            r_dps   <= w_dps_next;
            if (r_state == ST_PUBLISH)
                r_seen <= w_cap ? w_sel : 4'h0;
            else if (w_cap)
                r_seen <= r_seen | w_sel;
        end
    end

    // Load the published word as the frame completes so it is valid alongside frame_valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_value <= 16'h0;
            r_dp    <= 4'h0;
        end else if (w_go) begin
            r_value <= w_slots_next;
            r_dp    <= w_dps_next;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= ST_SCAN;
        else     r_state <= w_state_next;
    end

    // Next state: PUBLISH lasts exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_PUBLISH) w_state_next = ST_SCAN;
        else if (w_go)             w_state_next = ST_PUBLISH;
    end

`ifdef SEGCAP_ERR_EN
    logic r_err;

    // Sticky flag: a captured pattern decoded to 0 without being the real 0 glyph.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_err <= 1'b0;
        else     r_err <= r_err | (w_cap && (w_nib == 4'h0) && (r_s_seg[6:0] != 7'h40));
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif
endmodule
